mem_dados_arbiter: RTL and testbench
====================================

MEM_DADOS_ARBITER -- requirements
Module: mem_dados_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: data word width of both requester ports and the memory port.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: address width of both requester ports and the memory port.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each: access request from port 0 (CPU) and port 1 (I/O); each requester holds its request until granted.
REQ-006 The block SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read; valid while the matching req is high.
REQ-007 The block SHALL have ports addr0/addr1, input, ADDR_WIDTH each: access address for each port.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DATA_WIDTH each: write data for each port.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1 bit each: one-cycle grant pulse to the winning port.
REQ-010 The block SHALL have ports rvalid0/rvalid1, output, 1 bit each: one-cycle pulse marking read data valid.
REQ-011 The block SHALL have port rdata, output, DATA_WIDTH: read data, shared by both ports and qualified by rvalid0/rvalid1.
REQ-012 The block SHALL have ports mem_we, mem_read_addr, mem_write_addr and mem_data, outputs of width 1 / ADDR_WIDTH / ADDR_WIDTH / DATA_WIDTH: drive the data RAM.
REQ-013 The block SHALL have port mem_q, input, DATA_WIDTH: registered RAM read output, valid one clock after the read address is sampled.

Function
REQ-014 The block SHALL implement the states IDLE and RD_WAIT.
REQ-015 In IDLE with at least one req high, the block SHALL select one winner and assert that port's gnt combinationally in the same cycle; gnt0 and gnt1 are never high together.
REQ-016 Winner on a grant cycle, winner write: the block SHALL drive mem_we=1, mem_write_addr=addr, mem_data=wdata and remain in IDLE, giving a 1-cycle write with back-to-back grants possible.
REQ-017 Winner on a grant cycle, winner read: the block SHALL drive mem_read_addr=addr with mem_we=0, latch the winner ID and move to RD_WAIT.
REQ-018 In RD_WAIT the block SHALL:
- assert rvalid of the latched winner for exactly that cycle;
- drive rdata=mem_q;
- issue no grant;
- return to IDLE.
Read-grant to rvalid is 1 cycle; peak read throughput is 1 per 2 cycles.
REQ-019 Outside grant cycles the block SHALL hold mem_we=0; mem address and data outputs are don't-care but SHALL NOT create writes.
REQ-020 Round-robin: a 1-bit last-winner pointer SHALL update on every grant; when both req are high the port that is not the last winner wins.
REQ-021 A single requester SHALL win regardless of the pointer.
REQ-022 Requests arriving during RD_WAIT SHALL wait and be arbitrated in the following IDLE cycle.
REQ-023 rdata SHALL hold its last value when no rvalid is asserted.

Reset
REQ-024 With reset high at a clock edge, the block SHALL enter IDLE with pointer=1 (port 0 wins the first tie) and rdata=0.
REQ-025 While reset is high, gnt0, gnt1, rvalid0, rvalid1 and mem_we SHALL all be 0.
REQ-026 Reset asserted in RD_WAIT SHALL abort the read: no rvalid is issued for it, and the requester re-requests.

Configuration
REQ-027 Macro MEM_ARB_FIXED_PRIORITY_EN, when defined, SHALL make port 0 always win ties; the pointer is removed and port 1 may starve.
REQ-028 Without MEM_ARB_FIXED_PRIORITY_EN, the block SHALL use round-robin per REQ-020.

Verification
REQ-029 Post-reset write, single port: req0=1, we0=1, addr0=5, wdata0=0xA5A5 -> same cycle gnt0=1, mem_we=1, mem_write_addr=5, mem_data=0xA5A5.
REQ-030 Read, single port: req1=1, we1=0, addr1=5 -> gnt1 in cycle N; in cycle N+1 rvalid1=1, rdata=0xA5A5, gnt0=gnt1=0.
REQ-031 Tie, round-robin: req0 and req1 both writes held high 4 cycles after reset -> grants 0,1,0,1; with the macro defined -> 0,0,0,0.
REQ-032 Request during read: req0 read granted in cycle N, req1 write raised in cycle N -> gnt1 in cycle N+2, no grant in N+1.
REQ-033 Reset in RD_WAIT: reset high in the cycle after a read grant -> rvalid0=rvalid1=0 and mem_we=0; the next request is granted normally.

Source files
------------

// File: rtl/mem_dados_arbiter.sv
// mem_dados_arbiter: two-port (CPU / I/O) arbiter in front of a single-port data RAM.
// Latency: grant is combinational in IDLE; writes finish in the grant cycle; read data comes back one cycle after the grant.
// Backpressure: requesters hold req until granted; no grants are issued while a read is returning.
// Build option: define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 wins ties, port 1 may starve).
module mem_dados_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state;
  logic                  rd_id;     // port whose read is returning in RD_WAIT
  logic [DATA_WIDTH-1:0] rdata_q;   // last delivered read word
`ifndef MEM_ARB_FIXED_PRIORITY_EN
  logic                  last;      // last winner; the other port wins the next tie
`endif

  logic                  grant_any;
  logic                  win;       // 0 = port 0, 1 = port 1
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Pick the winner and steer its request onto the memory port.
  always_comb begin
    grant_any = (state == IDLE) && !reset && (req0 || req1);
    if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      win = 1'b0;
`else
      win = ~last;
`endif
    end else begin
      win = req1;
    end
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  // Grant pulses and memory drive; writes only ever happen on a grant cycle.
  always_comb begin
    gnt0           = grant_any && !win;
    gnt1           = grant_any &&  win;
    mem_we         = grant_any && win_we;
    mem_read_addr  = win_addr;
    mem_write_addr = win_addr;
    mem_data       = win_wdata;
  end

  // Read return: pulse rvalid of the latched port and pass mem_q through, else hold.
  always_comb begin
    rvalid0 = (state == RD_WAIT) && !reset && !rd_id;
    rvalid1 = (state == RD_WAIT) && !reset &&  rd_id;
    rdata   = (rvalid0 || rvalid1) ? mem_q : rdata_q;
  end

  // Arbitration FSM: a read grant moves to RD_WAIT for one cycle; reset aborts a pending read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      rd_id   <= 1'b0;
      rdata_q <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last <= win;
`endif
            if (!win_we) begin
              rd_id <= win;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          rdata_q <= mem_q;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dados_arbiter.sv
// Bench for mem_dados_arbiter: directed scenarios with literal expectations, then random traffic.
// A transaction-level model (pending read, tie pointer, reference memory) predicts every cycle's outputs.
// A small registered RAM model drives mem_q from the DUT's memory port.
module tb_mem_dados_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clock = 1'b0;
  logic          reset, req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_read_addr, mem_write_addr;

  int total = 0;
  int bad   = 0;

  mem_dados_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_we(mem_we), .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Registered RAM behind the arbiter (16 words are enough for the address range used).
  logic [DW-1:0] ram [16];
  always @(posedge clock) begin
    if (mem_we) ram[mem_write_addr[3:0]] <= mem_data;
    mem_q <= ram[mem_read_addr[3:0]];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model state.
  bit            m_pend;      // a granted read returns this cycle
  bit            m_port;
  logic [DW-1:0] m_rd;
  bit            m_last;      // last winner
  logic [DW-1:0] m_rdata;     // value rdata must hold
  bit            m_known;
  logic [DW-1:0] ref_mem [16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
    m_pend = 0; m_port = 0; m_rd = '0; m_last = 1; m_rdata = '0; m_known = 0;
  end

  // Per-cycle compare: inputs are stable between posedge+1 and the next posedge.
  always @(negedge clock) begin : cmp
    bit e_g0, e_g1, e_v0, e_v1, e_we, win, both;
    e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_we = 0; win = 0; both = 0;
    if (reset) begin
      check("m_gnt0", gnt0, 0);
      check("m_gnt1", gnt1, 0);
      check("m_rvalid", {rvalid0, rvalid1}, 0);
      check("m_mem_we", mem_we, 0);
      m_pend = 0; m_last = 1; m_rdata = '0; m_known = 1;
    end else begin
      if (m_pend) begin
        if (m_port) e_v1 = 1; else e_v0 = 1;
        check("m_rdata_rd", rdata, m_rd);
        m_rdata = m_rd;
        m_pend  = 0;
      end else begin
        if (m_known) check("m_rdata_hold", rdata, m_rdata);
        if (req0 || req1) begin
          both = req0 && req1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
          win = both ? 1'b0 : req1;
`else
          win = both ? !m_last : req1;
          m_last = win;
`endif
          if (win) e_g1 = 1; else e_g0 = 1;
          if (win ? we1 : we0) begin
            e_we = 1;
            check("m_waddr", mem_write_addr, win ? addr1 : addr0);
            check("m_wdata", mem_data, win ? wdata1 : wdata0);
            ref_mem[win ? addr1[3:0] : addr0[3:0]] = win ? wdata1 : wdata0;
          end else begin
            check("m_raddr", mem_read_addr, win ? addr1 : addr0);
            m_pend = 1;
            m_port = win;
            m_rd   = ref_mem[win ? addr1[3:0] : addr0[3:0]];
          end
        end
      end
      check("m_gnt0", gnt0, e_g0);
      check("m_gnt1", gnt1, e_g1);
      check("m_rvalid0", rvalid0, e_v0);
      check("m_rvalid1", rvalid1, e_v1);
      check("m_mem_we", mem_we, e_we);
    end
  end

  initial begin
    bit g0, g1;
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset with a pending write request: nothing may be granted or written.
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 32'hA5A5;
    @(negedge clock);
    check("rst_gnt0", gnt0, 0);
    check("rst_mem_we", mem_we, 0);
    @(posedge clock); #1; reset = 0;

    // Single-port write, same-cycle grant.
    @(negedge clock);
    check("wr_gnt0", gnt0, 1);
    check("wr_gnt1", gnt1, 0);
    check("wr_mem_we", mem_we, 1);
    check("wr_addr", mem_write_addr, 5);
    check("wr_data", mem_data, 32'hA5A5);
    @(posedge clock); #1; req0 = 0; req1 = 1; we1 = 0; addr1 = 5;

    // Single-port read: grant, then data one cycle later.
    @(negedge clock);
    check("rd_gnt1", gnt1, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_addr", mem_read_addr, 5);
    @(posedge clock); #1; req1 = 0;
    @(negedge clock);
    check("rd_rvalid1", rvalid1, 1);
    check("rd_rvalid0", rvalid0, 0);
    check("rd_rdata", rdata, 32'hA5A5);
    check("rd_nogrant", {gnt0, gnt1}, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("hold_rvalid1", rvalid1, 0);
    check("hold_rdata", rdata, 32'hA5A5);

    // Tie: both write for 4 cycles right after reset.
    @(posedge clock); #1; reset = 1;
    @(posedge clock); #1; reset = 0;
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 32'h1111;
    req1 = 1; we1 = 1; addr1 = 2; wdata1 = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      check("tie_gnt1", gnt1, 0);
      check("tie_gnt0", gnt0, 1);
`else
      check("tie_gnt1", gnt1, (i % 2 == 1));
      check("tie_gnt0", gnt0, (i % 2 == 0));
`endif
      @(posedge clock); #1;
    end

    // Read on port 0 granted in cycle N with a port-1 write raised in cycle N.
    we0 = 0; addr0 = 2;
    addr1 = 7; wdata1 = 32'h1234;
    @(negedge clock);
    check("rw_gnt0", gnt0, 1);
    check("rw_gnt1", gnt1, 0);
    @(posedge clock); #1; req0 = 0;
    @(negedge clock);
    check("rw_nogrant", {gnt0, gnt1}, 0);
    check("rw_rvalid0", rvalid0, 1);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    check("rw_rdata", rdata, 32'h0);
`else
    check("rw_rdata", rdata, 32'h2222);
`endif
    @(posedge clock); #1;
    @(negedge clock);
    check("rw_gnt1", gnt1, 1);
    check("rw_mem_we", mem_we, 1);
    check("rw_waddr", mem_write_addr, 7);
    @(posedge clock); #1; req1 = 0;

    // Reset in RD_WAIT aborts the read; the next request proceeds normally.
    req0 = 1; we0 = 0; addr0 = 5;
    @(negedge clock);
    check("ab_gnt0", gnt0, 1);
    @(posedge clock); #1; req0 = 0; reset = 1;
    @(negedge clock);
    check("ab_rvalid", {rvalid0, rvalid1}, 0);
    check("ab_mem_we", mem_we, 0);
    @(posedge clock); #1; reset = 0;
    req1 = 1; we1 = 1; addr1 = 3; wdata1 = 32'h77;
    @(negedge clock);
    check("ab_gnt1", gnt1, 1);
    check("ab_mem_we2", mem_we, 1);
    @(posedge clock); #1; req1 = 0;

    // Random traffic; requesters hold until granted, occasional resets.
    g0 = 0; g1 = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (req0 && g0) req0 = 0;
      if (req1 && g1) req1 = 0;
      if (!req0 && $urandom_range(0, 2) != 0) begin
        req0 = 1; we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) != 0) begin
        req1 = 1; we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
      end
      @(negedge clock);
      g0 = gnt0; g1 = gnt1;
      @(posedge clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
